// File: rtl/gaussian_stream_filter.sv
// 3x3 Gaussian blur over a raster pixel stream. Only interior pixels are emitted, through a first-word-fall-through output FIFO.
// Optional frame statistics (frame_done, frame_cnt) are built when GAUSS_FRAME_STATS_EN is defined.
module gaussian_stream_filter #(
    parameter int DATA_W     = 8,
    parameter int IMG_W      = 400,
    parameter int IMG_H      = 300,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    input  logic [DATA_W-1:0]             in_data,
    input  logic                          in_sof,
    output logic                          in_ready,
    output logic                          out_valid,
    output logic [DATA_W-1:0]             out_data,
    input  logic                          out_ready,
    output logic [$clog2(FIFO_DEPTH):0]   out_count,
    output logic                          err_sof
`ifdef GAUSS_FRAME_STATS_EN
    ,
    output logic                          frame_done,
    output logic [15:0]                   frame_cnt
`endif
);

    localparam int CW    = $clog2(IMG_W);
    localparam int RW    = $clog2(IMG_H);
    localparam int PW    = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PW + 1;
    localparam int SUM_W = DATA_W + 4;

    localparam logic [CW-1:0]    COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0]    ROW_LAST = RW'(IMG_H - 1);
    localparam logic [CNT_W-1:0] FULL     = CNT_W'(FIFO_DEPTH);

    // Handshakes: a beat moves on a rising clk edge where valid && ready are both high.
    // A producer's valid never waits on ready. in_ready is a function of FIFO occupancy
    // and the pipeline valids only, so it reserves a FIFO slot for every pixel in flight.

    logic              acc;
    logic [CW-1:0]     col, pix_col;
    logic [RW-1:0]     row, pix_row;
    logic              emit;

    logic [DATA_W-1:0] lb0 [IMG_W];
    logic [DATA_W-1:0] lb1 [IMG_W];
    logic [DATA_W-1:0] win [3][3];

    logic              s1_valid, s2_valid;
    logic [SUM_W-1:0]  sum_d, sum_q;
    logic [DATA_W-1:0] blur;

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr, rd_next;
    logic              fifo_wr, pop;
    logic [CNT_W:0]    occ;

    assign acc     = in_valid & in_ready;
    // An accepted start-of-frame overrides the tracked position for this very pixel
    assign pix_col = in_sof ? '0 : col;
    assign pix_row = in_sof ? '0 : row;
    assign emit    = (pix_row >= RW'(2)) && (pix_col >= CW'(2));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col     <= '0;
            row     <= '0;
            err_sof <= 1'b0;
        end else begin
            err_sof <= acc & in_sof & ((col != '0) | (row != '0));
            if (acc) begin
                if (pix_col == COL_LAST) begin
                    col <= '0;
                    row <= (pix_row == ROW_LAST) ? '0 : pix_row + 1'b1;
                end else begin
                    col <= pix_col + 1'b1;
                    row <= pix_row;
                end
            end
        end
    end

    // Line buffers and the window hold data only; validity travels in s1/s2_valid
    always_ff @(posedge clk) begin
        if (acc) begin
            lb1[pix_col] <= lb0[pix_col];
            lb0[pix_col] <= in_data;
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 2; c++) begin
                    win[r][c] <= win[r][c+1];
                end
            end
            win[0][2] <= lb1[pix_col];
            win[1][2] <= lb0[pix_col];
            win[2][2] <= in_data;
        end
        if (s1_valid) begin
            sum_q <= sum_d;
        end
    end

    always_comb begin
        sum_d = SUM_W'(win[0][0]) + SUM_W'(win[0][2]) + SUM_W'(win[2][0]) + SUM_W'(win[2][2])
              + ((SUM_W'(win[0][1]) + SUM_W'(win[1][0]) + SUM_W'(win[1][2]) + SUM_W'(win[2][1])) << 1)
              + (SUM_W'(win[1][1]) << 2);
    end

    // Round to nearest; 16*(2^DATA_W-1)+8 still fits in SUM_W bits
    assign blur = DATA_W'((sum_q + SUM_W'(8)) >> 4);

`ifdef GAUSS_FRAME_STATS_EN
    logic s1_last, s2_last;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
`ifdef GAUSS_FRAME_STATS_EN
            s1_last    <= 1'b0;
            s2_last    <= 1'b0;
            frame_done <= 1'b0;
            frame_cnt  <= '0;
`endif
        end else begin
            s1_valid <= acc & emit;
            s2_valid <= s1_valid;
`ifdef GAUSS_FRAME_STATS_EN
            s1_last    <= acc & emit & (pix_row == ROW_LAST) & (pix_col == COL_LAST);
            s2_last    <= s1_last;
            frame_done <= s2_valid & s2_last;
            if (s2_valid & s2_last) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
`endif
        end
    end

    assign fifo_wr = s2_valid;
    assign pop     = out_valid & out_ready;
    assign rd_next = rd_ptr + 1'b1;

    always_ff @(posedge clk) begin
        if (fifo_wr) begin
            mem[wr_ptr] <= blur;
        end
    end

    // out_valid/out_data form a registered head: an entry is shown one cycle after it is written
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            out_count <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            if (fifo_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_next;
            end
            out_count <= out_count + CNT_W'(fifo_wr) - CNT_W'(pop);
            if (pop) begin
                out_valid <= (out_count > CNT_W'(1));
                if (out_count > CNT_W'(1)) begin
                    out_data <= mem[rd_next];
                end
            end else if (!out_valid && (out_count != '0)) begin
                out_valid <= 1'b1;
                out_data  <= mem[rd_ptr];
            end
        end
    end

    assign occ      = {1'b0, out_count} + (CNT_W+1)'(s1_valid) + (CNT_W+1)'(s2_valid);
    assign in_ready = rst & (occ <= (CNT_W+1)'(FIFO_DEPTH - 1));

    fifo_no_overflow: assert property (@(posedge clk) disable iff (!rst) !(fifo_wr && (out_count == FULL)));

endmodule

// File: tb/tb_gaussian_stream_filter.sv
// Directed and randomized checks of gaussian_stream_filter on an 8x6 image with an 8-entry FIFO.
module tb_gaussian_stream_filter;

    localparam int DATA_W     = 8;
    localparam int IMG_W      = 8;
    localparam int IMG_H      = 6;
    localparam int FIFO_DEPTH = 8;
    localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1;
    localparam int N_PIX      = IMG_W * IMG_H;
    localparam int N_OUT      = (IMG_W - 2) * (IMG_H - 2);

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic [DATA_W-1:0] in_data = '0;
    logic              in_sof = 1'b0;
    logic              out_ready = 1'b0;
    logic              in_ready, out_valid, err_sof;
    logic [DATA_W-1:0] out_data;
    logic [CNT_W-1:0]  out_count;
`ifdef GAUSS_FRAME_STATS_EN
    logic              frame_done;
    logic [15:0]       frame_cnt;
    bit                seg6 = 1'b0;
`endif

    gaussian_stream_filter #(
        .DATA_W(DATA_W), .IMG_W(IMG_W), .IMG_H(IMG_H), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_data(in_data),
        .in_sof(in_sof),
        .in_ready(in_ready),
        .out_valid(out_valid),
        .out_data(out_data),
        .out_ready(out_ready),
        .out_count(out_count),
        .err_sof(err_sof)
`ifdef GAUSS_FRAME_STATS_EN
        ,
        .frame_done(frame_done),
        .frame_cnt(frame_cnt)
`endif
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // scoreboard state
    int                n_assert = 0;
    int                n_fail = 0;
    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] frame [IMG_H][IMG_W];
    int                pops = 0, err_pulses = 0, max_cnt = 0;
    int                prev_count = 0, wr_total = 0, fd_pulses = 0;
    bit                prev_pop = 1'b0, rand_rdy = 1'b0, rand_gap = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // One observation per cycle, taken 1 time unit after the rising edge
    task automatic observe();
        bit pop_now;
        int wr_now;
        pop_now = (out_valid === 1'b1) && (out_ready === 1'b1);
        if (pop_now) begin
            check("out_expected", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                check("out_data", out_data, exp_q[0]);
                void'(exp_q.pop_front());
            end
            pops++;
        end
        if (err_sof === 1'b1) err_pulses++;
        if (int'(out_count) > max_cnt) max_cnt = int'(out_count);
        check("count_le_depth", 32'(int'(out_count) <= FIFO_DEPTH), 1);
        wr_now = int'(out_count) - prev_count + int'(prev_pop);
        if (wr_now > 0) wr_total += wr_now;
`ifdef GAUSS_FRAME_STATS_EN
        if (frame_done === 1'b1) begin
            fd_pulses++;
            if (seg6) begin
                check("fd_on_write", wr_now, 1);
                check("fd_on_last_of_frame", wr_total % N_OUT, 0);
            end
        end
`endif
        prev_count = int'(out_count);
        prev_pop   = pop_now;
    endtask

    task automatic tick();
        observe();
        @(posedge clk);
        #1;
        if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    // driver tasks
    task automatic send(input logic [DATA_W-1:0] d, input logic sof);
        bit ok, rdy;
        ok = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_sof   = sof;
        for (int k = 0; k < 300; k++) begin
            rdy = in_ready;
            tick();
            if (rdy) begin
                ok = 1'b1;
                break;
            end
        end
        in_valid = 1'b0;
        in_sof   = 1'b0;
        check("send_accepted", 32'(ok), 1);
    endtask

    task automatic send_pixels(input int first, input int last, input bit sof_first);
        for (int idx = first; idx <= last; idx++) begin
            if (rand_gap && ($urandom_range(0, 3) == 0)) tick();
            send(frame[idx / IMG_W][idx % IMG_W], sof_first && (idx == first));
        end
    endtask

    task automatic fill_frame(input int mode, input logic [DATA_W-1:0] v);
        for (int r = 0; r < IMG_H; r++) begin
            for (int c = 0; c < IMG_W; c++) begin
                if (mode == 0) frame[r][c] = v;
                else if (mode == 1) frame[r][c] = (r == 3 && c == 3) ? v : '0;
                else frame[r][c] = DATA_W'($urandom_range(0, 255));
            end
        end
    endtask

    // Reference: each accepted pixel at (r,c) with r,c >= 2 yields the blur centred at (r-1,c-1)
    task automatic push_model(input int n_pixels);
        int r, c, sum, wr, wc;
        for (int idx = 0; idx < n_pixels; idx++) begin
            r = idx / IMG_W;
            c = idx % IMG_W;
            if (r >= 2 && c >= 2) begin
                sum = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        wr = (dr == 0) ? 2 : 1;
                        wc = (dc == 0) ? 2 : 1;
                        sum += wr * wc * int'(frame[r - 1 + dr][c - 1 + dc]);
                    end
                end
                exp_q.push_back(DATA_W'((sum + 8) / 16));
            end
        end
    endtask

    task automatic drain_to(input int remaining);
        for (int k = 0; k < 500; k++) begin
            if (exp_q.size() == remaining && out_valid !== 1'b1 && out_count == '0) break;
            tick();
        end
        check("drain_queue", exp_q.size(), remaining);
        check("drain_count", out_count, 0);
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_count", out_count, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_err_sof", err_sof, 0);
        exp_q.delete();
        prev_count = 0;
        prev_pop   = 1'b0;
        wr_total   = 0;
        fd_pulses  = 0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    initial begin
        int p0, e0, dr, dc;

        // reset state
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        check("reset_out_valid", out_valid, 0);
        check("reset_out_data", out_data, 0);
        check("reset_out_count", out_count, 0);
        check("reset_err_sof", err_sof, 0);
        check("reset_in_ready", in_ready, 0);
        tick();
        rst = 1'b1;
        #1;
        check("release_in_ready", in_ready, 1);
        tick();

        // flat frame: 24 outputs of 100, first out_valid 3 cycles after pixel (2,2)
        fill_frame(0, 8'd100);
        push_model(N_PIX);
        p0 = pops;
        out_ready = 1'b1;
        send_pixels(0, 2 * IMG_W + 1, 1'b1);
        send_pixels(2 * IMG_W + 2, 2 * IMG_W + 2, 1'b0);
        check("lat_c0_valid", out_valid, 0);
        tick();
        check("lat_c1_valid", out_valid, 0);
        tick();
        check("lat_c2_valid", out_valid, 0);
        check("lat_c2_count", out_count, 1);
        tick();
        check("lat_c3_valid", out_valid, 1);
        check("lat_c3_data", out_data, 100);
        send_pixels(2 * IMG_W + 3, N_PIX - 1, 1'b0);
        drain_to(0);
        check("flat_outputs", pops - p0, N_OUT);

        // impulse at (3,3): expectations written from the kernel weights directly
        fill_frame(1, 8'd255);
        for (int r = 2; r < IMG_H; r++) begin
            for (int c = 2; c < IMG_W; c++) begin
                dr = (r - 1 > 3) ? (r - 4) : (4 - r);
                dc = (c - 1 > 3) ? (c - 4) : (4 - c);
                if (dr == 0 && dc == 0) exp_q.push_back(8'd64);
                else if (dr + dc == 1) exp_q.push_back(8'd32);
                else if (dr == 1 && dc == 1) exp_q.push_back(8'd16);
                else exp_q.push_back(8'd0);
            end
        end
        p0 = pops;
        send_pixels(0, N_PIX - 1, 1'b1);
        drain_to(0);
        check("impulse_outputs", pops - p0, N_OUT);

        // back-pressure: consumer stalled, random frame, counters wrap without sof
        fill_frame(2, '0);
        push_model(N_PIX);
        p0 = pops;
        max_cnt = 0;
        out_ready = 1'b0;
        send_pixels(0, 3 * IMG_W + 3, 1'b0);
        check("bp_in_ready_low", in_ready, 0);
        tick();
        tick();
        tick();
        check("bp_in_ready_held", in_ready, 0);
        check("bp_count_full", out_count, FIFO_DEPTH);
        check("bp_out_valid", out_valid, 1);
        check("bp_no_pops", pops - p0, 0);
        out_ready = 1'b1;
        send_pixels(3 * IMG_W + 4, N_PIX - 1, 1'b0);
        drain_to(0);
        check("bp_peak", max_cnt, FIFO_DEPTH);
        check("bp_outputs", pops - p0, N_OUT);

        // sof at (2,5) mid-frame restarts counters and flags err_sof once
        rand_rdy = 1'b1;
        rand_gap = 1'b1;
        e0 = err_pulses;
        p0 = pops;
        fill_frame(2, '0);
        push_model(2 * IMG_W + 5);
        send_pixels(0, 2 * IMG_W + 4, 1'b1);
        fill_frame(2, '0);
        push_model(N_PIX);
        send(frame[0][0], 1'b1);
        check("sof_err_pulse", err_sof, 1);
        tick();
        check("sof_err_clear", err_sof, 0);
        send_pixels(1, N_PIX - 1, 1'b0);
        drain_to(0);
        check("sof_err_count", err_pulses - e0, 1);
        check("sof_outputs", pops - p0, 3 + N_OUT);

        // two random frames back to back, no sof, random ready and gaps
        p0 = pops;
        for (int f = 0; f < 2; f++) begin
            fill_frame(2, '0);
            push_model(N_PIX);
            send_pixels(0, N_PIX - 1, 1'b0);
        end
        drain_to(0);
        check("wrap_outputs", pops - p0, 2 * N_OUT);
        check("wrap_no_err", err_pulses - e0, 1);

        // reset mid-frame at (4,3) with five results held
        rand_rdy = 1'b0;
        rand_gap = 1'b0;
        out_ready = 1'b1;
        fill_frame(2, '0);
        push_model(4 * IMG_W + 4);
        p0 = pops;
        send_pixels(0, 3 * IMG_W + 4, 1'b0);
        drain_to(5);
        check("rst_mid_popped", pops - p0, 9);
        out_ready = 1'b0;
        send_pixels(3 * IMG_W + 5, 4 * IMG_W + 3, 1'b0);
        tick();
        tick();
        tick();
        check("rst_mid_held", out_count, 5);
        check("rst_mid_valid", out_valid, 1);
        apply_reset();
        out_ready = 1'b1;
        fill_frame(0, 8'd100);
        push_model(N_PIX);
        p0 = pops;
        send_pixels(0, N_PIX - 1, 1'b0);
        drain_to(0);
        check("after_rst_outputs", pops - p0, N_OUT);
        check("after_rst_no_err", err_pulses - e0, 1);

`ifdef GAUSS_FRAME_STATS_EN
        // frame statistics over three flat frames
        apply_reset();
        seg6 = 1'b1;
        for (int f = 0; f < 3; f++) begin
            fill_frame(0, 8'd100);
            push_model(N_PIX);
            send_pixels(0, N_PIX - 1, f == 0);
        end
        drain_to(0);
        check("frame_done_pulses", fd_pulses, 3);
        check("frame_cnt", frame_cnt, 3);
        seg6 = 1'b0;
`endif

        // final report
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
